// File: rtl/read_flash_controller.sv
// Single-word Avalon-MM read master for the on-board flash (burst count 1).
// Define READ_FLASH_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES and flag `error`.
module read_flash_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        RST,
    output logic        flash_mem_write,
    output logic [6:0]  flash_mem_burstcount,
    input  logic        flash_mem_waitrequest,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [31:0] flash_mem_writedata,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic [3:0]  flash_mem_byteenable,
    input  logic [22:0] MEM_ADDR,
    output logic [31:0] DATA,
    input  logic        read,
    output logic        busy,
    output logic        error
);

    typedef enum logic [7:0] {
        IDLE                = 8'h00,
        SEND_READ_REQUEST_0 = 8'h01,
        SEND_READ_REQUEST_1 = 8'h02,
        WAIT_VALID_READ_0   = 8'h03,
        VALID_READ_SAVE     = 8'h04
    } state_t;

    state_t     state;
    logic [7:0] state_code;
    logic       abort;

    assign state_code = state;

    assign flash_mem_write      = 1'b0;
    assign flash_mem_burstcount = 7'd1;
    assign flash_mem_writedata  = '0;
    assign flash_mem_byteenable = 4'hF;

`ifdef READ_FLASH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt;
    logic             in_wait;

    assign in_wait = (state == SEND_READ_REQUEST_0) || (state == WAIT_VALID_READ_0);
    assign abort   = in_wait && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in either stall state; restarts whenever the FSM leaves them.
    always_ff @(posedge clk) begin
        if (!RST || !in_wait || abort) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end
`else
    assign abort = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state             <= IDLE;
            DATA              <= '0;
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
            busy              <= 1'b0;
            error             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read) begin
                        flash_mem_address <= MEM_ADDR;
                        flash_mem_read    <= 1'b1;
                        busy              <= 1'b1;
                        error             <= 1'b0;
                        state             <= SEND_READ_REQUEST_0;
                    end
                end
                SEND_READ_REQUEST_0: begin
                    if (abort) begin
                        flash_mem_read <= 1'b0;
                        busy           <= 1'b0;
                        error          <= 1'b1;
                        state          <= IDLE;
                    end else if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        state          <= SEND_READ_REQUEST_1;
                    end
                end
                SEND_READ_REQUEST_1: begin
                    if (flash_mem_readdatavalid) begin
                        DATA  <= flash_mem_readdata;
                        state <= VALID_READ_SAVE;
                    end else begin
                        state <= WAIT_VALID_READ_0;
                    end
                end
                WAIT_VALID_READ_0: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= IDLE;
                    end else if (flash_mem_readdatavalid) begin
                        DATA  <= flash_mem_readdata;
                        state <= VALID_READ_SAVE;
                    end
                end
                VALID_READ_SAVE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    flash_mem_read <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_flash_controller.sv
// Randomized self-checking bench for read_flash_controller; a flash responder and an
// expected-DATA model live here. Timeout scenario is built only with READ_FLASH_TIMEOUT_EN.
module tb_read_flash_controller;

    logic        clk = 1'b0;
    logic        RST;
    logic        flash_mem_write;
    logic [6:0]  flash_mem_burstcount;
    logic        flash_mem_waitrequest;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [31:0] flash_mem_writedata;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [3:0]  flash_mem_byteenable;
    logic [22:0] MEM_ADDR;
    logic [31:0] DATA;
    logic        read;
    logic        busy;
    logic        error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    read_flash_controller dut (
        .clk                     (clk),
        .RST                     (RST),
        .flash_mem_write         (flash_mem_write),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_writedata     (flash_mem_writedata),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .MEM_ADDR                (MEM_ADDR),
        .DATA                    (DATA),
        .read                    (read),
        .busy                    (busy),
        .error                   (error)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_constants(input string tag);
        n_cmp++;
        if ({flash_mem_write, flash_mem_burstcount, flash_mem_byteenable, flash_mem_writedata} !==
            {1'b0, 7'd1, 4'hF, 32'h0}) begin
            n_bad++;
            $display("FAIL const_%s: write=%b burst=%0d be=%h wdata=%h, required 0/1/f/0",
                     tag, flash_mem_write, flash_mem_burstcount, flash_mem_byteenable, flash_mem_writedata);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        read = 1'b0;
        MEM_ADDR = '0;
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata = '0;
        repeat (2) @(negedge clk);
        exp_data = '0;
        n_cmp++;
        if ({dut.state_code, DATA, flash_mem_read, flash_mem_address, busy, error} !==
            {8'h00, 32'h0, 1'b0, 23'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: state=%h data=%h rd=%b addr=%h busy=%b err=%b, required all zero",
                     dut.state_code, DATA, flash_mem_read, flash_mem_address, busy, error);
        end
        test_constants("reset");
        RST = 1'b1;
    endtask

    // One transaction: `stall` cycles of waitrequest, then valid `lat` cycles after acceptance.
    // poke_read pulses `read` with another address while busy; hold_read keeps `read` high.
    task automatic run_txn(input logic [22:0] addr, input int stall, input int lat,
                           input logic [31:0] rdata, input bit poke_read, input bit hold_read);
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        n_cmp++;
        if (DATA !== exp_data || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_before: data=%h busy=%b, required %h/0", DATA, busy, exp_data);
        end
        MEM_ADDR = addr;
        read = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            n_cmp++;
            if (flash_mem_read !== 1'b1 || flash_mem_address !== addr || busy !== 1'b1 || error !== 1'b0) begin
                n_bad++;
                $display("FAIL request_%0d: rd=%b addr=%h busy=%b err=%b, required 1/%h/1/0",
                         i, flash_mem_read, flash_mem_address, busy, error, addr);
            end
            flash_mem_waitrequest = (i < stall);
            if (poke_read && i == 0) begin
                read = 1'b1;
                MEM_ADDR = ~addr;
            end else if (!hold_read) begin
                read = 1'b0;
                MEM_ADDR = addr;
            end
            @(negedge clk);
        end
        flash_mem_waitrequest = 1'($urandom);
        for (int j = 1; j <= lat; j++) begin
            if (!hold_read) read = 1'b0;
            n_cmp++;
            if (flash_mem_read !== 1'b0 || busy !== 1'b1 || flash_mem_address !== addr ||
                DATA !== exp_data || dut.state_code !== ((j == 1) ? 8'h02 : 8'h03)) begin
                n_bad++;
                $display("FAIL await_%0d: rd=%b busy=%b addr=%h data=%h state=%h, required 0/1/%h/%h/%h",
                         j, flash_mem_read, busy, flash_mem_address, DATA, dut.state_code,
                         addr, exp_data, (j == 1) ? 8'h02 : 8'h03);
            end
            flash_mem_readdatavalid = (j == lat);
            flash_mem_readdata = (j == lat) ? rdata : $urandom;
            @(negedge clk);
        end
        exp_data = rdata;
        flash_mem_readdatavalid = 1'($urandom);
        flash_mem_readdata = $urandom;
        n_cmp++;
        if (DATA !== exp_data || busy !== 1'b1 || dut.state_code !== 8'h04) begin
            n_bad++;
            $display("FAIL capture: data=%h busy=%b state=%h, required %h/1/04",
                     DATA, busy, dut.state_code, exp_data);
        end
        @(negedge clk);
        flash_mem_readdatavalid = 1'($urandom);
        flash_mem_readdata = $urandom;
        n_cmp++;
        if (DATA !== exp_data || busy !== 1'b0 || dut.state_code !== 8'h00 || flash_mem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL done: data=%h busy=%b state=%h rd=%b, required %h/0/00/0",
                     DATA, busy, dut.state_code, flash_mem_read, exp_data);
        end
    endtask

    task automatic test_no_stall();
        run_txn(23'h00000A, 0, 2, 32'h0000000A, 1'b0, 1'b0);
    endtask

    task automatic test_waitrequest_stall();
        run_txn(23'h00000A, 8, 2, 32'h0000000A, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(23'h000010, 2, 3, 32'h00000010, 1'b1, 1'b0);
        run_txn(23'h7FFFFF, 0, 1, 32'h007FFFFF, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_txn(23'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(1, 5)),
                    $urandom, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_retrigger();
        run_txn(23'h055AA5, 1, 2, 32'hCAFE0001, 1'b0, 1'b1);
        flash_mem_waitrequest = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || dut.state_code !== 8'h01 || flash_mem_read !== 1'b1 ||
            flash_mem_address !== 23'h055AA5) begin
            n_bad++;
            $display("FAIL retrigger: busy=%b state=%h rd=%b addr=%h, required 1/01/1/055aa5",
                     busy, dut.state_code, flash_mem_read, flash_mem_address);
        end
        read = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        MEM_ADDR = 23'h000005;
        read = 1'b1;
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        @(negedge clk);
        read = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut.state_code !== 8'h03) begin
            n_bad++;
            $display("FAIL mid_setup: state=%h, required 03", dut.state_code);
        end
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        exp_data = '0;
        n_cmp++;
        if ({dut.state_code, DATA, busy, flash_mem_read} !== {8'h00, 32'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset: state=%h data=%h busy=%b rd=%b, required 00/0/0/0",
                     dut.state_code, DATA, busy, flash_mem_read);
        end
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'hDEADBEEF;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        n_cmp++;
        if (DATA !== 32'h0 || dut.state_code !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL late_valid: data=%h state=%h busy=%b, required 0/00/0",
                     DATA, dut.state_code, busy);
        end
        test_constants("mid");
    endtask

`ifdef READ_FLASH_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        run_txn(23'h000ABC, 0, 1, 32'h12345678, 1'b0, 1'b0);
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        MEM_ADDR = 23'h000123;
        read = 1'b1;
        flash_mem_waitrequest = 1'b1;
        @(negedge clk);
        read = 1'b0;
        n = 0;
        while (error !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (error !== 1'b1 || n != 255) begin
            n_bad++;
            $display("FAIL timeout: error=%b after %0d cycles, required 1 after 255", error, n);
        end
        n_cmp++;
        if (dut.state_code !== 8'h00 || busy !== 1'b0 || flash_mem_read !== 1'b0 || DATA !== exp_data) begin
            n_bad++;
            $display("FAIL timeout_state: state=%h busy=%b rd=%b data=%h, required 00/0/0/%h",
                     dut.state_code, busy, flash_mem_read, DATA, exp_data);
        end
        flash_mem_waitrequest = 1'b0;
        run_txn(23'h000321, 0, 2, 32'h00000321, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_no_stall();
        test_waitrequest_stall();
        test_back_to_back();
        test_random();
        test_retrigger();
        test_reset();
        test_reset_mid_read();
`ifdef READ_FLASH_TIMEOUT_EN
        test_timeout();
`endif
        test_constants("end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
